// File: rtl/l2_refill_pkg.sv
// Shared definitions for the L2 refill engines (icache now, dcache later).
package l2_refill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_UPD  = 2'd2
  } refill_state_t;

  localparam int WORD_BYTES = 4;

  // Clears the byte-in-line offset bits so the result points at the first word of the line.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int idx_w);
    logic [31:0] mask;
    mask = (32'(WORD_BYTES) << idx_w) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/l2_beat_timer.sv
// Counts granted cycles within one L2 read beat. Losing the grant restarts the beat,
// so only an unbroken run of L2_RD_LAT granted cycles produces beat_done.
module l2_beat_timer #(
  parameter int L2_RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic grant,
  output logic beat_done
);

  localparam int CNT_W = (L2_RD_LAT > 1) ? $clog2(L2_RD_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(L2_RD_LAT - 1);

  logic [CNT_W-1:0] lat_cnt;

  assign beat_done = active && grant && (lat_cnt == LAST_CNT);

  // Advance on each granted cycle; any gap, an inactive engine or a finished beat restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
    end else if (!active || !grant || beat_done) begin
      lat_cnt <= '0;
    end else begin
      lat_cnt <= lat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/icache_l2_refill_ctrl.sv
// Icache miss-refill engine: fetches a whole line from L2 one word per beat, writes each
// word into the icache data array, then pulses upd_entry_icache to commit tag/valid.
// Read-only L2 master.
module icache_l2_refill_ctrl
  import l2_refill_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int L2_RD_LAT      = 1,
  localparam int IDX_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             miss_valid,
  input  logic [31:0]      miss_addr,
  input  logic             flush,
  output logic             busy,
  output logic             refill_done,
  output logic             l2_mem_en_icache,
  output logic             l2_mem_wr_en_icache,
  output logic [31:0]      l2_mem_access_addr_icache,
  output logic [31:0]      l2_mem_wr_data_icache,
  input  logic [31:0]      l2_mem_rd_data_icache,
  input  logic             rd_grant_icache_active,
  output logic             fill_wr_en,
  output logic [IDX_W-1:0] fill_word_idx,
  output logic [31:0]      fill_data,
  output logic [31:0]      fill_line_addr,
  output logic             upd_entry_icache
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_UPD  = ST_UPD;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [IDX_W-1:0] word_idx;
  logic             in_req;
  logic             beat_done;
  logic             accept_miss;

  assign in_req      = (state == S_REQ);
  assign accept_miss = (state == S_IDLE) && miss_valid && !flush;

  l2_beat_timer #(
    .L2_RD_LAT (L2_RD_LAT)
  ) u_beat_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (in_req && !flush),
    .grant     (rd_grant_icache_active),
    .beat_done (beat_done)
  );

  // Next-state selection; flush overrides everything and returns to IDLE.
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (miss_valid) next_state = S_REQ;
        S_REQ:   if (beat_done && (word_idx == LAST_IDX)) next_state = S_UPD;
        S_UPD:   next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Line address capture, word sequencing and the one-cycle fill write into the data array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx       <= '0;
      fill_line_addr <= '0;
      fill_data      <= '0;
      fill_word_idx  <= '0;
      fill_wr_en     <= 1'b0;
    end else begin
      fill_wr_en <= beat_done;
      if (beat_done) begin
        fill_data     <= l2_mem_rd_data_icache;
        fill_word_idx <= word_idx;
        word_idx      <= word_idx + IDX_W'(1);
      end
      if (flush) begin
        word_idx <= '0;
      end else if (accept_miss) begin
        fill_line_addr <= line_align(miss_addr, IDX_W);
        word_idx       <= '0;
      end
    end
  end

  // Bus request and commit strobes decode straight from the state; a flush in UPD suppresses the commit.
  always_comb begin
    busy                      = (state != S_IDLE);
    l2_mem_en_icache          = in_req;
    l2_mem_access_addr_icache = in_req ? (fill_line_addr + 32'({word_idx, 2'b00})) : 32'd0;
    upd_entry_icache          = (state == S_UPD) && !flush;
    refill_done               = (state == S_UPD) && !flush;
    l2_mem_wr_en_icache       = 1'b0;
    l2_mem_wr_data_icache     = 32'd0;
  end

endmodule

// File: tb/tb_icache_l2_refill_ctrl.sv
// Bench for icache_l2_refill_ctrl: one instance with single-cycle L2 reads and one with
// three-cycle reads. Expected fill words are queued when a miss is issued and checked
// as the engine writes them.
module tb_icache_l2_refill_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic        miss_valid1, flush1, grant1;
  logic [31:0] miss_addr1, rd_data1;
  logic        busy1, done1, en1, wr_en1, fill_wr_en1, upd1;
  logic [31:0] addr1, wr_data1, fill_data1, line1;
  logic [1:0]  idx1;

  logic        miss_valid3, flush3, grant3;
  logic [31:0] miss_addr3, rd_data3;
  logic        busy3, done3, en3, wr_en3, fill_wr_en3, upd3;
  logic [31:0] addr3, wr_data3, fill_data3, line3;
  logic [1:0]  idx3;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
  } fill_t;

  fill_t       q1[$];
  fill_t       q3[$];
  logic [31:0] exp_line1, exp_line3;
  int          upd_cnt1, upd_cnt3, upd_exp1, upd_exp3;
  int          n_checks, n_fail;
  logic [1:0]  b_lat;

  always #5 clk = ~clk;

  function automatic logic [31:0] l2_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  assign rd_data1 = grant1 ? l2_word(addr1) : 32'hDEAD_BEEF;
  assign rd_data3 = (en3 && grant3 && (b_lat == 2'd2)) ? l2_word(addr3) : 32'hDEAD_BEEF;

  icache_l2_refill_ctrl #(.WORDS_PER_LINE(4), .L2_RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .miss_valid(miss_valid1), .miss_addr(miss_addr1), .flush(flush1),
    .busy(busy1), .refill_done(done1), .l2_mem_en_icache(en1), .l2_mem_wr_en_icache(wr_en1),
    .l2_mem_access_addr_icache(addr1), .l2_mem_wr_data_icache(wr_data1),
    .l2_mem_rd_data_icache(rd_data1), .rd_grant_icache_active(grant1),
    .fill_wr_en(fill_wr_en1), .fill_word_idx(idx1), .fill_data(fill_data1),
    .fill_line_addr(line1), .upd_entry_icache(upd1));

  icache_l2_refill_ctrl #(.WORDS_PER_LINE(4), .L2_RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .miss_valid(miss_valid3), .miss_addr(miss_addr3), .flush(flush3),
    .busy(busy3), .refill_done(done3), .l2_mem_en_icache(en3), .l2_mem_wr_en_icache(wr_en3),
    .l2_mem_access_addr_icache(addr3), .l2_mem_wr_data_icache(wr_data3),
    .l2_mem_rd_data_icache(rd_data3), .rd_grant_icache_active(grant3),
    .fill_wr_en(fill_wr_en3), .fill_word_idx(idx3), .fill_data(fill_data3),
    .fill_line_addr(line3), .upd_entry_icache(upd3));

  // L2 model latency tracker: data for the 3-cycle instance is valid only on the last granted cycle of a beat.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_lat <= 2'd0;
    else if (en3 && grant3) b_lat <= (b_lat == 2'd2) ? 2'd0 : b_lat + 2'd1;
    else b_lat <= 2'd0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one miss to the selected instance and queue the line words it must write.
  task automatic applyStimulus(input int dut, input logic [31:0] addr);
    logic [31:0] base;
    base = addr & 32'hFFFF_FFF0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (dut == 1) q1.push_back('{idx: 2'(i), data: l2_word(base + 32'(4 * i))});
      else          q3.push_back('{idx: 2'(i), data: l2_word(base + 32'(4 * i))});
    end
    if (dut == 1) begin
      miss_valid1 = 1'b1; miss_addr1 = addr; exp_line1 = base; upd_exp1++;
    end else begin
      miss_valid3 = 1'b1; miss_addr3 = addr; exp_line3 = base; upd_exp3++;
    end
    @(posedge clk); #1;
    miss_valid1 = 1'b0;
    miss_valid3 = 1'b0;
  endtask

  task automatic waitIdle(input int dut, input int budget, input string tag);
    int c;
    for (c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!((dut == 1) ? busy1 : busy3)) break;
    end
    checkOutput(tag, 32'(c < budget), 32'd1);
  endtask

  // Scoreboard monitor for the single-cycle instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fill_wr_en1) begin
        if (q1.size() == 0) checkOutput("u1_fill_unexpected", 32'd1, 32'd0);
        else begin
          fill_t e;
          e = q1.pop_front();
          checkOutput("u1_fill_idx", 32'(idx1), 32'(e.idx));
          checkOutput("u1_fill_data", fill_data1, e.data);
        end
      end
      if (upd1) begin
        upd_cnt1++;
        checkOutput("u1_done_with_upd", 32'(done1), 32'd1);
        checkOutput("u1_commit_line", line1, exp_line1);
      end else if (done1) checkOutput("u1_done_without_upd", 32'd1, 32'd0);
    end
  end

  // Scoreboard monitor for the three-cycle instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fill_wr_en3) begin
        if (q3.size() == 0) checkOutput("u3_fill_unexpected", 32'd1, 32'd0);
        else begin
          fill_t e;
          e = q3.pop_front();
          checkOutput("u3_fill_idx", 32'(idx3), 32'(e.idx));
          checkOutput("u3_fill_data", fill_data3, e.data);
        end
      end
      if (upd3) begin
        upd_cnt3++;
        checkOutput("u3_done_with_upd", 32'(done3), 32'd1);
        checkOutput("u3_commit_line", line3, exp_line3);
      end else if (done3) checkOutput("u3_done_without_upd", 32'd1, 32'd0);
    end
  end

  initial begin
    int snap;
    int reached;
    logic [31:0] ra;
    n_checks = 0; n_fail = 0;
    upd_cnt1 = 0; upd_cnt3 = 0; upd_exp1 = 0; upd_exp3 = 0;
    exp_line1 = '0; exp_line3 = '0;
    rst_n = 1'b0;
    miss_valid1 = 0; flush1 = 0; grant1 = 0; miss_addr1 = '0;
    miss_valid3 = 0; flush3 = 0; grant3 = 0; miss_addr3 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy1), 32'd0);
    checkOutput("rst_l2_en", 32'(en1), 32'd0);
    checkOutput("rst_fill_wr_en", 32'(fill_wr_en1), 32'd0);
    checkOutput("rst_upd", 32'(upd1), 32'd0);
    checkOutput("rst_addr", addr1, 32'd0);
    checkOutput("rst_line", line1, 32'd0);
    checkOutput("rst_wr_en_tied", 32'(wr_en1), 32'd0);
    checkOutput("rst_busy3", 32'(busy3), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Uncontended refill with single-cycle reads
    $display("[TB] uncontended refill");
    grant1 = 1'b1;
    applyStimulus(1, 32'h0000_1234);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("u1_req_en", 32'(en1), 32'd1);
      checkOutput("u1_beat_addr", addr1, 32'h0000_1230 + 32'(4 * k));
      checkOutput("u1_wr_en_tied", 32'(wr_en1), 32'd0);
    end
    @(negedge clk);
    checkOutput("u1_upd_cycle", 32'(upd1), 32'd1);
    checkOutput("u1_upd_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    checkOutput("u1_upd_one_cycle", 32'(upd1), 32'd0);
    checkOutput("u1_idle_after_upd", 32'(busy1), 32'd0);

    // Flush in REQ at word index 2, then a fresh miss
    $display("[TB] flush mid refill");
    applyStimulus(1, 32'h0000_4440);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush1 = 1'b1;
    @(posedge clk); #1;
    flush1 = 1'b0;
    q1.delete();
    upd_exp1--;
    snap = upd_cnt1;
    @(negedge clk);
    checkOutput("flush_busy", 32'(busy1), 32'd0);
    checkOutput("flush_no_fill", 32'(fill_wr_en1), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("flush_no_commit", 32'(upd_cnt1), 32'(snap));
    applyStimulus(1, 32'h0000_2000);
    waitIdle(1, 20, "u1_after_flush_idle");
    checkOutput("after_flush_commit", 32'(upd_cnt1), 32'(snap + 1));

    // Miss and flush together in IDLE: flush wins
    @(posedge clk); #1;
    miss_valid1 = 1'b1; flush1 = 1'b1; miss_addr1 = 32'h0000_9990;
    @(posedge clk); #1;
    miss_valid1 = 1'b0; flush1 = 1'b0;
    @(negedge clk);
    checkOutput("miss_flush_dropped", 32'(busy1), 32'd0);

    // Miss pulses while busy are ignored
    $display("[TB] miss while busy");
    snap = upd_cnt1;
    applyStimulus(1, 32'h0000_3000);
    miss_valid1 = 1'b1; miss_addr1 = 32'h0000_5550;
    @(posedge clk); #1;
    @(posedge clk); #1;
    miss_valid1 = 1'b0;
    waitIdle(1, 20, "u1_busy_miss_idle");
    repeat (3) @(negedge clk);
    checkOutput("busy_miss_ignored", 32'(busy1), 32'd0);
    checkOutput("busy_miss_one_commit", 32'(upd_cnt1), 32'(snap + 1));

    // Asynchronous reset mid REQ
    $display("[TB] async reset mid refill");
    applyStimulus(1, 32'h0000_6000);
    @(posedge clk); #3;
    rst_n = 1'b0;
    q1.delete();
    upd_exp1--;
    #1;
    checkOutput("arst_busy", 32'(busy1), 32'd0);
    checkOutput("arst_l2_en", 32'(en1), 32'd0);
    checkOutput("arst_fill_wr_en", 32'(fill_wr_en1), 32'd0);
    checkOutput("arst_addr", addr1, 32'd0);
    checkOutput("arst_line", line1, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    snap = upd_cnt1;
    applyStimulus(1, 32'h0000_7008);
    waitIdle(1, 20, "u1_after_reset_idle");
    checkOutput("after_reset_commit", 32'(upd_cnt1), 32'(snap + 1));

    // Three-cycle reads with the grant dropped on the second cycle of beat 1
    $display("[TB] grant loss restart");
    grant3 = 1'b1;
    applyStimulus(3, 32'h0000_8004);
    repeat (4) @(posedge clk);
    #1 grant3 = 1'b0;
    @(posedge clk); #1;
    grant3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("restart_no_early_fill", 32'(fill_wr_en3), 32'd0);
    end
    @(negedge clk);
    checkOutput("restart_fill_en", 32'(fill_wr_en3), 32'd1);
    checkOutput("restart_fill_idx", 32'(idx3), 32'd1);
    waitIdle(3, 40, "u3_restart_idle");

    // 100 misses with a randomly stalling grant
    $display("[TB] random grant stalls");
    for (int m = 0; m < 100; m++) begin
      ra = $urandom;
      applyStimulus(3, ra);
      reached = 0;
      for (int c = 0; c < 800; c++) begin
        @(posedge clk); #1;
        grant3 = 1'($urandom_range(0, 1));
        if (!busy3) begin
          reached = 1;
          break;
        end
      end
      checkOutput("u3_rand_idle", 32'(reached), 32'd1);
    end

    repeat (2) @(negedge clk);
    checkOutput("u1_queue_drained", 32'(q1.size()), 32'd0);
    checkOutput("u3_queue_drained", 32'(q3.size()), 32'd0);
    checkOutput("u1_commit_count", 32'(upd_cnt1), 32'(upd_exp1));
    checkOutput("u3_commit_count", 32'(upd_cnt3), 32'(upd_exp3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
